nios_system_timer_seq: RTL



---
 rtl/nios_system_timer_seq_if.sv | 28 ++
 rtl/nios_system_timer_seq.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/nios_system_timer_seq_if.sv
// Command/response handshake plus Avalon-MM timer bus for nios_system_timer_seq.
// master: sequencer view (drives timer bus, consumes commands); slave: requester/timer view.
interface nios_system_timer_seq_if;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_op;
    logic [31:0] cmd_period;
    logic        rsp_valid;
    logic [31:0] rsp_data;
    logic [2:0]  tmr_address;
    logic        tmr_chipselect;
    logic        tmr_write_n;
    logic [15:0] tmr_writedata;
    logic [15:0] tmr_readdata;
    logic        tmr_irq;

    modport master (
        input  cmd_valid, cmd_op, cmd_period, tmr_readdata, tmr_irq,
        output cmd_ready, rsp_valid, rsp_data,
               tmr_address, tmr_chipselect, tmr_write_n, tmr_writedata
    );

    modport slave (
        output cmd_valid, cmd_op, cmd_period, tmr_readdata, tmr_irq,
        input  cmd_ready, rsp_valid, rsp_data,
               tmr_address, tmr_chipselect, tmr_write_n, tmr_writedata
    );
endinterface

// File: rtl/nios_system_timer_seq.sv
// Avalon-MM sequencer for the 16-bit-register interval timer: start/stop, snapshot, IRQ service.
// Define TMRSEQ_SNAPSHOT_EN to build the SNAPSHOT read path; otherwise op 2 responds with zero.
module nios_system_timer_seq #(
    parameter bit          CONT_MODE = 1'b1,
    parameter int unsigned EVT_W     = 16
) (
    input  logic                 clk,
    input  logic                 reset_n,
    nios_system_timer_seq_if.master bus,
    output logic [EVT_W-1:0]     event_count,
    output logic                 event_pulse
);

    localparam logic [2:0]  ADDR_STATUS = 3'd0;
    localparam logic [2:0]  ADDR_CTRL   = 3'd1;
    localparam logic [2:0]  ADDR_PER_L  = 3'd2;
    localparam logic [2:0]  ADDR_PER_H  = 3'd3;
    localparam logic [2:0]  ADDR_SNAP_L = 3'd4;
    localparam logic [2:0]  ADDR_SNAP_H = 3'd5;
    localparam logic [15:0] CTRL_START  = {12'b0, 1'b0, 1'b1, CONT_MODE, 1'b1};
    localparam logic [15:0] CTRL_STOP   = 16'h0008;

    localparam logic [1:0] OP_START = 2'd0;
    localparam logic [1:0] OP_STOP  = 2'd1;
    localparam logic [1:0] OP_SNAP  = 2'd2;
    localparam logic [1:0] OP_CLR   = 2'd3;

    typedef enum logic [3:0] {
        IDLE, WR_PL, WR_PH, WR_CTRL, STOP_WR, SNAP_WR,
        RD_L, RD_H, RD_DONE, IRQ_ACK, RESP
    } state_t;

    state_t      state, state_nxt;
    logic        accept;
    logic [15:0] period_hi;

    assign bus.cmd_ready = (state == IDLE) && !bus.tmr_irq;
    assign accept        = bus.cmd_ready && bus.cmd_valid;

    // Next-state: a pending IRQ in IDLE wins over any command
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (bus.tmr_irq) begin
                    state_nxt = IRQ_ACK;
                end else if (bus.cmd_valid) begin
                    case (bus.cmd_op)
                        OP_START: state_nxt = WR_PL;
                        OP_STOP:  state_nxt = STOP_WR;
`ifdef TMRSEQ_SNAPSHOT_EN
                        OP_SNAP:  state_nxt = SNAP_WR;
`else
                        OP_SNAP:  state_nxt = RESP;
`endif
                        default:  state_nxt = RESP;
                    endcase
                end
            end
            WR_PL:   state_nxt = WR_PH;
            WR_PH:   state_nxt = WR_CTRL;
            WR_CTRL: state_nxt = RESP;
            STOP_WR: state_nxt = RESP;
`ifdef TMRSEQ_SNAPSHOT_EN
            SNAP_WR: state_nxt = RD_L;
            RD_L:    state_nxt = RD_H;
            RD_H:    state_nxt = RD_DONE;
            RD_DONE: state_nxt = RESP;
`endif
            IRQ_ACK: state_nxt = IDLE;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

`ifdef TMRSEQ_SNAPSHOT_EN
    logic [15:0] snap_lo;
    logic [31:0] snap_q;
`else
    logic unused_readdata;
    assign unused_readdata = ^bus.tmr_readdata;
`endif

    // State register; bus outputs are registered from the state being entered
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state              <= IDLE;
            period_hi          <= '0;
            event_count        <= '0;
            event_pulse        <= 1'b0;
            bus.rsp_valid      <= 1'b0;
            bus.rsp_data       <= '0;
            bus.tmr_chipselect <= 1'b0;
            bus.tmr_write_n    <= 1'b1;
            bus.tmr_address    <= '0;
            bus.tmr_writedata  <= '0;
`ifdef TMRSEQ_SNAPSHOT_EN
            snap_lo            <= '0;
            snap_q             <= '0;
`endif
        end else begin
            state              <= state_nxt;
            event_pulse        <= 1'b0;
            bus.rsp_valid      <= 1'b0;
            bus.tmr_chipselect <= 1'b0;
            bus.tmr_write_n    <= 1'b1;
            bus.tmr_address    <= '0;
            bus.tmr_writedata  <= '0;

            if (accept) period_hi <= bus.cmd_period[31:16];
            if (accept && (bus.cmd_op == OP_CLR)) event_count <= '0;

            case (state_nxt)
                WR_PL: begin
                    bus.tmr_chipselect <= 1'b1;
                    bus.tmr_write_n    <= 1'b0;
                    bus.tmr_address    <= ADDR_PER_L;
                    bus.tmr_writedata  <= bus.cmd_period[15:0];
                end
                WR_PH: begin
                    bus.tmr_chipselect <= 1'b1;
                    bus.tmr_write_n    <= 1'b0;
                    bus.tmr_address    <= ADDR_PER_H;
                    bus.tmr_writedata  <= period_hi;
                end
                WR_CTRL: begin
                    bus.tmr_chipselect <= 1'b1;
                    bus.tmr_write_n    <= 1'b0;
                    bus.tmr_address    <= ADDR_CTRL;
                    bus.tmr_writedata  <= CTRL_START;
                end
                STOP_WR: begin
                    bus.tmr_chipselect <= 1'b1;
                    bus.tmr_write_n    <= 1'b0;
                    bus.tmr_address    <= ADDR_CTRL;
                    bus.tmr_writedata  <= CTRL_STOP;
                end
                SNAP_WR: begin
                    bus.tmr_chipselect <= 1'b1;
                    bus.tmr_write_n    <= 1'b0;
                    bus.tmr_address    <= ADDR_SNAP_L;
                end
                RD_L: begin
                    bus.tmr_chipselect <= 1'b1;
                    bus.tmr_address    <= ADDR_SNAP_L;
                end
                RD_H: begin
                    bus.tmr_chipselect <= 1'b1;
                    bus.tmr_address    <= ADDR_SNAP_H;
                end
                IRQ_ACK: begin
                    bus.tmr_chipselect <= 1'b1;
                    bus.tmr_write_n    <= 1'b0;
                    bus.tmr_address    <= ADDR_STATUS;
                    event_pulse        <= 1'b1;
                    event_count        <= event_count + EVT_W'(1);
                end
                RESP:    bus.rsp_valid <= 1'b1;
                default: ;
            endcase

`ifdef TMRSEQ_SNAPSHOT_EN
            // Slave read data lags the address by one cycle
            if (state == RD_H)    snap_lo <= bus.tmr_readdata;
            if (state == RD_DONE) snap_q  <= {bus.tmr_readdata, snap_lo};
            if (state_nxt == RESP) begin
                bus.rsp_data <= (state == RD_DONE) ? {bus.tmr_readdata, snap_lo} : 32'h0;
            end else if (state == RESP) begin
                bus.rsp_data <= snap_q;
            end
`endif
        end
    end

endmodule
